// File: rtl/ip_tx_nexthop_resolver_if.sv
// ip_tx_nexthop_resolver_if: header, payload, ARP, config and status signals of the next-hop resolver
interface ip_tx_nexthop_resolver_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  s_ip_hdr_valid;
    logic                  s_ip_hdr_ready;
    logic [31:0]           s_ip_dest_ip;
    logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep;
    logic                  s_ip_payload_axis_tvalid;
    logic                  s_ip_payload_axis_tready;
    logic                  s_ip_payload_axis_tlast;
    logic                  s_ip_payload_axis_tuser;
    logic                  m_ip_hdr_valid;
    logic                  m_ip_hdr_ready;
    logic [47:0]           m_eth_dest_mac;
    logic [DATA_WIDTH-1:0] m_ip_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_ip_payload_axis_tkeep;
    logic                  m_ip_payload_axis_tvalid;
    logic                  m_ip_payload_axis_tready;
    logic                  m_ip_payload_axis_tlast;
    logic                  m_ip_payload_axis_tuser;
    logic                  arp_request_valid;
    logic                  arp_request_ready;
    logic [31:0]           arp_request_ip;
    logic                  arp_response_valid;
    logic                  arp_response_ready;
    logic                  arp_response_error;
    logic [47:0]           arp_response_mac;
    logic [31:0]           local_ip;
    logic [31:0]           gateway_ip;
    logic [31:0]           subnet_mask;
    logic                  busy;
    logic                  tx_error_arp_failed;
    logic [15:0]           drop_count;

    modport slave (
        input  s_ip_hdr_valid, s_ip_dest_ip,
        input  s_ip_payload_axis_tdata, s_ip_payload_axis_tkeep, s_ip_payload_axis_tvalid,
        input  s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
        input  m_ip_hdr_ready, m_ip_payload_axis_tready,
        input  arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        input  local_ip, gateway_ip, subnet_mask,
        output s_ip_hdr_ready, s_ip_payload_axis_tready,
        output m_ip_hdr_valid, m_eth_dest_mac,
        output m_ip_payload_axis_tdata, m_ip_payload_axis_tkeep, m_ip_payload_axis_tvalid,
        output m_ip_payload_axis_tlast, m_ip_payload_axis_tuser,
        output arp_request_valid, arp_request_ip, arp_response_ready,
        output busy, tx_error_arp_failed, drop_count
    );

    modport master (
        output s_ip_hdr_valid, s_ip_dest_ip,
        output s_ip_payload_axis_tdata, s_ip_payload_axis_tkeep, s_ip_payload_axis_tvalid,
        output s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
        output m_ip_hdr_ready, m_ip_payload_axis_tready,
        output arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        output local_ip, gateway_ip, subnet_mask,
        input  s_ip_hdr_ready, s_ip_payload_axis_tready,
        input  m_ip_hdr_valid, m_eth_dest_mac,
        input  m_ip_payload_axis_tdata, m_ip_payload_axis_tkeep, m_ip_payload_axis_tvalid,
        input  m_ip_payload_axis_tlast, m_ip_payload_axis_tuser,
        input  arp_request_valid, arp_request_ip, arp_response_ready,
        input  busy, tx_error_arp_failed, drop_count
    );
endinterface

// File: rtl/ip_tx_nexthop_resolver.sv
// ip_tx_nexthop_resolver: resolves the next-hop MAC of an outgoing IP packet via ARP and gates its payload
module ip_tx_nexthop_resolver #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ARP_TIMEOUT = 1024,
    parameter int ARP_RETRIES = 2
) (
    input logic                     clk,
    input logic                     rst,
    ip_tx_nexthop_resolver_if.slave bus
);
    localparam logic [2:0]  IDLE       = 3'd0;
    localparam logic [2:0]  ARP_REQ    = 3'd1;
    localparam logic [2:0]  ARP_WAIT   = 3'd2;
    localparam logic [2:0]  HDR_OUT    = 3'd3;
    localparam logic [2:0]  PASS       = 3'd4;
    localparam logic [2:0]  DROP       = 3'd5;
    localparam logic [15:0] TMO_LAST   = 16'(ARP_TIMEOUT - 1);
    localparam logic [2:0]  RETRY_INIT = 3'(ARP_RETRIES);

    logic [2:0]            state_q, state_d;
    logic [47:0]           mac_q, mac_d;
    logic [31:0]           nh_q, nh_d;
    logic [2:0]            retry_q, retry_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  hdr_ready, arp_failed;
    logic [31:0]           dest, host_mask;
    logic                  is_bcast, is_mcast, on_link;
    logic                  in_pass, in_drop, s_tready, last_beat;
    logic                  rsp_ok, attempt_over;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;

    assign dest      = bus.s_ip_dest_ip;
    assign host_mask = ~bus.subnet_mask;
    // an all-ones mask has no host bits, so only the limited broadcast address counts then
    assign is_bcast  = (&dest) || (host_mask != '0 && (dest & host_mask) == host_mask);
    assign is_mcast  = dest[31:28] == 4'hE;
    assign on_link   = ((dest ^ bus.local_ip) & bus.subnet_mask) == '0;

    assign in_pass   = rst && state_q == PASS;
    assign in_drop   = rst && state_q == DROP;
    assign s_tready  = in_pass ? bus.m_ip_payload_axis_tready : in_drop;
    assign last_beat = bus.s_ip_payload_axis_tvalid && s_tready && bus.s_ip_payload_axis_tlast;

    assign rsp_ok       = bus.arp_response_valid && !bus.arp_response_error;
    assign attempt_over = bus.arp_response_valid || tmo_q == TMO_LAST;

    assign tdata = bus.s_ip_payload_axis_tdata;
    assign tkeep = bus.s_ip_payload_axis_tkeep;
    assign bus.m_ip_payload_axis_tdata  = tdata;
    assign bus.m_ip_payload_axis_tkeep  = tkeep;
    assign bus.m_ip_payload_axis_tlast  = bus.s_ip_payload_axis_tlast;
    assign bus.m_ip_payload_axis_tuser  = bus.s_ip_payload_axis_tuser;
    assign bus.m_ip_payload_axis_tvalid = in_pass && bus.s_ip_payload_axis_tvalid;
    assign bus.s_ip_payload_axis_tready = s_tready;

    assign bus.s_ip_hdr_ready      = rst && hdr_ready;
    assign bus.m_ip_hdr_valid      = rst && state_q == HDR_OUT;
    assign bus.m_eth_dest_mac      = mac_q;
    assign bus.arp_request_valid   = rst && state_q == ARP_REQ;
    assign bus.arp_request_ip      = nh_q;
    assign bus.arp_response_ready  = rst && state_q == ARP_WAIT;
    assign bus.busy                = state_q != IDLE;
    assign bus.tx_error_arp_failed = rst && arp_failed;
    assign bus.drop_count          = drop_cnt_q;

    always_comb begin
        state_d    = state_q;
        mac_d      = mac_q;
        nh_d       = nh_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        drop_cnt_d = drop_cnt_q;
        hdr_ready  = 1'b0;
        arp_failed = 1'b0;
        case (state_q)
            IDLE: if (bus.s_ip_hdr_valid) begin
                if (is_bcast || is_mcast) begin
                    mac_d     = is_bcast ? '1 : {24'h01005E, 1'b0, dest[22:0]};
                    hdr_ready = 1'b1;
                    state_d   = HDR_OUT;
                end else begin
                    nh_d    = on_link ? dest : bus.gateway_ip;
                    retry_d = RETRY_INIT;
                    state_d = ARP_REQ;
                end
            end
            ARP_REQ: if (bus.arp_request_ready) begin
                tmo_d   = '0;
                state_d = ARP_WAIT;
            end
            ARP_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                // a good answer in the timeout cycle still wins over the timeout
                if (rsp_ok) begin
                    mac_d     = bus.arp_response_mac;
                    hdr_ready = 1'b1;
                    state_d   = HDR_OUT;
                end else if (attempt_over && retry_q != '0) begin
                    retry_d = retry_q - 3'd1;
                    state_d = ARP_REQ;
                end else if (attempt_over) begin
                    hdr_ready  = 1'b1;
                    arp_failed = 1'b1;
                    drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 16'd1;
                    state_d    = DROP;
                end
            end
            HDR_OUT: state_d = bus.m_ip_hdr_ready ? PASS : HDR_OUT;
            PASS, DROP: state_d = last_beat ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mac_q      <= '0;
            nh_q       <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mac_q      <= mac_d;
            nh_q       <= nh_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule
